// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone classic arbiter.
package wb_arb_pkg;

  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    OWN_I,
    OWN_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle: master drives the request, slave drives the response.
interface wb_arbiter_if;
  import wb_arb_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [SEL_W-1:0] sel;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: fires for one cycle when the owner has waited TIMEOUT cycles
// with stb high and no ack/err. TIMEOUT=0 removes the counter entirely.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic timeout
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, active, stb, ack, err};
      assign timeout       = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] count;
      logic             stalled;

      assign stalled = active && stb && !ack && !err;
      // An ack or err in the final cycle keeps stalled low, so the slave wins the race.
      assign timeout = stalled && (count == CNT_W'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          count <= '0;
        end else if (!stalled || timeout) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave port between the
// rv32_cpu instruction and data buses, with cycle locking and a stall watchdog.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  ibus,
  wb_arbiter_if.slave  dbus,
  wb_arbiter_if.master mbus
);

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_grant_nxt;
  logic       own_active;
  logic       own_stb;
  logic       timeout;

  assign own_active = (state != IDLE);
  assign own_stb    = (state == OWN_I) ? ibus.stb :
                      (state == OWN_D) ? dbus.stb : 1'b0;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (own_active),
    .stb     (own_stb),
    .ack     (mbus.ack),
    .err     (mbus.err),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Ownership always passes through IDLE, which gives the fixed one-cycle gap between owners.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (ibus.cyc && dbus.cyc) begin
          if (last_grant == GNT_I) begin
            state_nxt      = OWN_D;
            last_grant_nxt = GNT_D;
          end else begin
            state_nxt      = OWN_I;
            last_grant_nxt = GNT_I;
          end
        end else if (ibus.cyc) begin
          state_nxt      = OWN_I;
          last_grant_nxt = GNT_I;
        end else if (dbus.cyc) begin
          state_nxt      = OWN_D;
          last_grant_nxt = GNT_D;
        end
      end
      OWN_I: begin
        if (!ibus.cyc || timeout) state_nxt = IDLE;
      end
      OWN_D: begin
        if (!dbus.cyc || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A watchdog abort drops cyc/stb toward the slave in the same cycle the owner sees err.
  always_comb begin
    mbus.adr   = '0;
    mbus.dat_w = '0;
    mbus.sel   = '0;
    mbus.cyc   = 1'b0;
    mbus.stb   = 1'b0;
    mbus.we    = 1'b0;
    mbus.cti   = '0;
    mbus.bte   = '0;
    ibus.ack   = 1'b0;
    ibus.err   = 1'b0;
    dbus.ack   = 1'b0;
    dbus.err   = 1'b0;
    ibus.dat_r = mbus.dat_r;
    dbus.dat_r = mbus.dat_r;
    case (state)
      OWN_I: begin
        mbus.adr   = ibus.adr;
        mbus.dat_w = ibus.dat_w;
        mbus.sel   = ibus.sel;
        mbus.cyc   = ibus.cyc & ~timeout;
        mbus.stb   = ibus.stb & ~timeout;
        mbus.we    = ibus.we;
        mbus.cti   = ibus.cti;
        mbus.bte   = ibus.bte;
        ibus.ack   = mbus.ack;
        ibus.err   = mbus.err | timeout;
      end
      OWN_D: begin
        mbus.adr   = dbus.adr;
        mbus.dat_w = dbus.dat_w;
        mbus.sel   = dbus.sel;
        mbus.cyc   = dbus.cyc & ~timeout;
        mbus.stb   = dbus.stb & ~timeout;
        mbus.we    = dbus.we;
        mbus.cti   = dbus.cti;
        mbus.bte   = dbus.bte;
        dbus.ack   = mbus.ack;
        dbus.err   = mbus.err | timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a cycle-level ownership model.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_arbiter_if ibus_if ();
  wb_arbiter_if dbus_if ();
  wb_arbiter_if mbus_if ();

  wb_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ibus (ibus_if),
    .dbus (dbus_if),
    .mbus (mbus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner 0=none, 1=ibus, 2=dbus; last is the most recent owner.
  int m_owner = 0;
  int m_last  = 1;
  int m_stall = 0;

  function automatic logic [79:0] pack_req(
    input logic cyc, input logic stb, input logic we, input logic [29:0] adr,
    input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    return {6'b0, cyc, stb, we, adr, dat, sel, cti, bte};
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ci, input bit si, input bit cd,
                               input bit sd, input bit ma, input bit me);
    rst           = r;
    ibus_if.cyc   = ci;
    ibus_if.stb   = si;
    ibus_if.adr   = 30'($urandom);
    ibus_if.dat_w = $urandom;
    ibus_if.sel   = 4'($urandom);
    ibus_if.we    = 1'($urandom);
    ibus_if.cti   = 3'($urandom);
    ibus_if.bte   = 2'($urandom);
    dbus_if.cyc   = cd;
    dbus_if.stb   = sd;
    dbus_if.adr   = 30'($urandom);
    dbus_if.dat_w = $urandom;
    dbus_if.sel   = 4'($urandom);
    dbus_if.we    = 1'($urandom);
    dbus_if.cti   = 3'($urandom);
    dbus_if.bte   = 2'($urandom);
    mbus_if.ack   = ma;
    mbus_if.err   = me;
    mbus_if.dat_r = $urandom;
    #1;
  endtask

  // Compare every output with the model, then advance one clock and update the model.
  task automatic cycle();
    logic [79:0] ereq;
    logic [1:0]  ei, ed;
    bit          fire, o_cyc, o_stb;
    int          n_owner, n_last, n_stall;
    ereq = '0;
    ei   = 2'b00;
    ed   = 2'b00;
    fire = 1'b0;
    if (m_owner == 1) begin
      fire = ibus_if.stb && !mbus_if.ack && !mbus_if.err && (m_stall == TO - 1);
      ereq = pack_req(ibus_if.cyc && !fire, ibus_if.stb && !fire, ibus_if.we, ibus_if.adr,
                      ibus_if.dat_w, ibus_if.sel, ibus_if.cti, ibus_if.bte);
      ei   = {mbus_if.ack, mbus_if.err | fire};
    end else if (m_owner == 2) begin
      fire = dbus_if.stb && !mbus_if.ack && !mbus_if.err && (m_stall == TO - 1);
      ereq = pack_req(dbus_if.cyc && !fire, dbus_if.stb && !fire, dbus_if.we, dbus_if.adr,
                      dbus_if.dat_w, dbus_if.sel, dbus_if.cti, dbus_if.bte);
      ed   = {mbus_if.ack, mbus_if.err | fire};
    end
    checkOutput("mbus_req", pack_req(mbus_if.cyc, mbus_if.stb, mbus_if.we, mbus_if.adr,
                mbus_if.dat_w, mbus_if.sel, mbus_if.cti, mbus_if.bte), ereq);
    checkOutput("ibus_resp", {78'b0, ibus_if.ack, ibus_if.err}, {78'b0, ei});
    checkOutput("dbus_resp", {78'b0, dbus_if.ack, dbus_if.err}, {78'b0, ed});
    checkOutput("ibus_dat_r", {48'b0, ibus_if.dat_r}, {48'b0, mbus_if.dat_r});
    checkOutput("dbus_dat_r", {48'b0, dbus_if.dat_r}, {48'b0, mbus_if.dat_r});

    n_owner = m_owner;
    n_last  = m_last;
    n_stall = m_stall;
    if (rst) begin
      n_owner = 0;
      n_last  = 1;
      n_stall = 0;
    end else if (m_owner == 0) begin
      if (ibus_if.cyc && dbus_if.cyc) n_owner = (m_last == 1) ? 2 : 1;
      else if (ibus_if.cyc)           n_owner = 1;
      else if (dbus_if.cyc)           n_owner = 2;
      if (n_owner != 0) n_last = n_owner;
      n_stall = 0;
    end else begin
      o_cyc = (m_owner == 1) ? ibus_if.cyc : dbus_if.cyc;
      o_stb = (m_owner == 1) ? ibus_if.stb : dbus_if.stb;
      if (!o_cyc || fire) begin
        n_owner = 0;
        n_stall = 0;
      end else begin
        n_stall = (o_stb && !mbus_if.ack && !mbus_if.err) ? m_stall + 1 : 0;
      end
    end
    @(posedge clk);
    m_owner = n_owner;
    m_last  = n_last;
    m_stall = n_stall;
    @(negedge clk);
  endtask

  initial begin
    bit ci, cd;
    rst = 1'b1;
    applyStimulus(1, 1, 1, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Reset held with both masters requesting, then D wins because last_grant=I.
    repeat (2) begin
      applyStimulus(1, 1, 1, 1, 1, 0, 0);
      checkOutput("rst_mbus_cyc", {79'b0, mbus_if.cyc}, 80'd0);
      checkOutput("rst_acks", {78'b0, ibus_if.ack, dbus_if.ack}, 80'd0);
      cycle();
    end
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    checkOutput("post_rst_idle", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    checkOutput("post_rst_grant_d", {49'b0, mbus_if.cyc, mbus_if.adr}, {49'b0, 1'b1, dbus_if.adr});
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Single ibus transfer with one wait state.
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    ibus_if.adr = 30'h100;
    #1;
    checkOutput("i_only_t0", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    ibus_if.adr = 30'h100;
    #1;
    checkOutput("i_only_t1", {49'b0, mbus_if.cyc, mbus_if.adr}, {49'b0, 1'b1, 30'h100});
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 1, 0);
    ibus_if.adr   = 30'h100;
    mbus_if.dat_r = 32'hDEADBEEF;
    #1;
    checkOutput("i_only_ack", {78'b0, ibus_if.ack, dbus_if.ack}, {78'b0, 2'b10});
    checkOutput("i_only_dat", {48'b0, ibus_if.dat_r}, {48'b0, 32'hDEADBEEF});
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Contention: D, dead cycle, I, dead cycle, D.
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    checkOutput("cont_idle0", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 1, 0);
    checkOutput("cont_grant_d", {50'b0, mbus_if.adr}, {50'b0, dbus_if.adr});
    checkOutput("cont_d_ack", {78'b0, ibus_if.ack, dbus_if.ack}, {78'b0, 2'b01});
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    checkOutput("cont_dead", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 1, 0);
    checkOutput("cont_grant_i", {50'b0, mbus_if.adr}, {50'b0, ibus_if.adr});
    checkOutput("cont_i_ack", {78'b0, ibus_if.ack, dbus_if.ack}, {78'b0, 2'b10});
    cycle();
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    checkOutput("cont_dead2", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();

    // Lock: dbus keeps cyc through three stb phases while ibus waits.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 1, 1, 1, 0);
      checkOutput("lock_adr", {50'b0, mbus_if.adr}, {50'b0, dbus_if.adr});
      checkOutput("lock_ack", {78'b0, ibus_if.ack, dbus_if.ack}, {78'b0, 2'b01});
      cycle();
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      checkOutput("lock_gap", {78'b0, mbus_if.cyc, mbus_if.stb}, {78'b0, 2'b10});
      cycle();
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    cycle();

    // Watchdog abort on the 4th stalled cycle, then a late ack that beats it.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      checkOutput("to_wait", {78'b0, mbus_if.cyc, ibus_if.err}, {78'b0, 2'b10});
      cycle();
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("to_fire", {76'b0, mbus_if.cyc, mbus_if.stb, ibus_if.ack, ibus_if.err},
                {76'b0, 4'b0001});
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("to_idle", {79'b0, mbus_if.cyc}, 80'd0);
    cycle();
    repeat (3) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      cycle();
    end
    applyStimulus(0, 1, 1, 0, 0, 1, 0);
    checkOutput("to_late_ack", {77'b0, mbus_if.cyc, ibus_if.ack, ibus_if.err}, {77'b0, 3'b110});
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Slave err routed to dbus only; reset during an ibus stall drops the cycle.
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    checkOutput("serr_route", {78'b0, ibus_if.err, dbus_if.err}, {78'b0, 2'b01});
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("rst_mid_own", {79'b0, mbus_if.cyc}, {79'b0, 1'b1});
    cycle();
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    checkOutput("rst_mid_resp", {78'b0, ibus_if.ack, ibus_if.err}, 80'd0);
    cycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("rst_mid_drop", {77'b0, mbus_if.cyc, ibus_if.ack, ibus_if.err}, 80'd0);
    cycle();

    // Randomized traffic with sticky cyc so locking and timeouts both occur.
    ci = 1'b0;
    cd = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) ci = ~ci;
      if ($urandom_range(0, 4) == 0) cd = ~cd;
      applyStimulus($urandom_range(0, 99) == 0,
                    ci, ci && ($urandom_range(0, 3) != 0),
                    cd, cd && ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
